// File: rtl/cmac_link_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmac_link_pkg
// Description : Shared types, default parameters and helpers for the CMAC
//               link monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package cmac_link_pkg;

    typedef enum logic [2:0] {
        S_RESET = 3'd0,
        S_WAIT  = 3'd1,
        S_QUAL  = 3'd2,
        S_UP    = 3'd3,
        S_DOWN  = 3'd4
    } link_state_t;

    typedef struct packed {
        logic cmac_reset;
        logic tx_enable;
        logic send_rfi;
        logic link_up;
    } link_ctl_t;

    localparam int c_reset_hold_cyc_dflt    = 16;
    localparam int c_align_timeout_cyc_dflt = 100_000_000;
    localparam int c_debounce_cyc_dflt      = 1000;
    localparam int c_cnt_w_dflt             = 16;

    // The timer counts 0..N-1 for each parameter N, so clog2 of the largest suffices.
    function automatic int timer_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

    // S_DOWN keeps the S_UP outputs so short alignment glitches stay invisible.
    function automatic link_ctl_t decode_ctl(input link_state_t s);
        link_ctl_t ctl;
        ctl.cmac_reset = (s == S_RESET);
        ctl.tx_enable  = (s == S_UP) || (s == S_DOWN);
        ctl.send_rfi   = !((s == S_UP) || (s == S_DOWN));
        ctl.link_up    = (s == S_UP) || (s == S_DOWN);
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmac_link_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : cmac_link_monitor_if
// Description : Status/control bundle between the link monitor (master) and
//               the CMAC core (slave). link_drops exists with CMAC_LINK_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface cmac_link_monitor_if
    import cmac_link_pkg::*;
#(
    parameter int CNT_W = c_cnt_w_dflt
);
    logic             stat_rx_aligned;
    logic             cmac_reset;
    logic             ctl_tx_enable;
    logic             ctl_tx_send_rfi;
    logic             link_up;
    logic [CNT_W-1:0] retry_count;
`ifdef CMAC_LINK_STATS_EN
    logic [CNT_W-1:0] link_drops;
`endif

    modport master (
        input  stat_rx_aligned,
        output cmac_reset,
        output ctl_tx_enable,
        output ctl_tx_send_rfi,
        output link_up,
`ifdef CMAC_LINK_STATS_EN
        output link_drops,
`endif
        output retry_count
    );

    modport slave (
        output stat_rx_aligned,
        input  cmac_reset,
        input  ctl_tx_enable,
        input  ctl_tx_send_rfi,
        input  link_up,
`ifdef CMAC_LINK_STATS_EN
        input  link_drops,
`endif
        input  retry_count
    );
endinterface
`default_nettype wire

// File: rtl/cdc_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : cdc_bit_sync
// Description : N-stage single-bit synchronizer into the clk domain.
// Revision    : 1.0 - initial release
// ============================================================================
module cdc_bit_sync #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);
    if (STAGES < 2) begin : g_param_check
        $error("cdc_bit_sync: STAGES must be >= 2");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[STAGES-1];
endmodule
`default_nettype wire

// File: rtl/cmac_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cmac_link_monitor
// Description : CMAC link bring-up / supervision FSM; re-resets the core on
//               alignment timeout or sustained loss. Option: CMAC_LINK_STATS_EN
//               adds the link_drops counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cmac_link_monitor
    import cmac_link_pkg::*;
#(
    parameter int RESET_HOLD_CYC    = c_reset_hold_cyc_dflt,
    parameter int ALIGN_TIMEOUT_CYC = c_align_timeout_cyc_dflt,
    parameter int DEBOUNCE_CYC      = c_debounce_cyc_dflt,
    parameter int CNT_W             = c_cnt_w_dflt
) (
    input  wire logic            init_clk,
    input  wire logic            init_reset,
    cmac_link_monitor_if.master  link
);
    if (RESET_HOLD_CYC < 2 || ALIGN_TIMEOUT_CYC < 2 || DEBOUNCE_CYC < 2) begin : g_param_check
        $error("cmac_link_monitor: cycle parameters must all be >= 2");
    end

    localparam int c_timer_w = timer_width(RESET_HOLD_CYC, ALIGN_TIMEOUT_CYC, DEBOUNCE_CYC);
    localparam logic [c_timer_w-1:0] c_hold_last     = c_timer_w'(RESET_HOLD_CYC - 1);
    localparam logic [c_timer_w-1:0] c_timeout_last  = c_timer_w'(ALIGN_TIMEOUT_CYC - 1);
    localparam logic [c_timer_w-1:0] c_debounce_last = c_timer_w'(DEBOUNCE_CYC - 1);

    logic                 w_aligned_s;
    link_state_t          r_state;
    link_state_t          w_state_nxt;
    logic [c_timer_w-1:0] r_timer;
    logic                 w_retry_inc;
    link_ctl_t            r_ctl;
    logic [CNT_W-1:0]     r_retry_count;

    cdc_bit_sync #(
        .STAGES  (2)
    ) u_aligned_sync (
        .clk     (init_clk),
        .rst     (init_reset),
        .i_async (link.stat_rx_aligned),
        .o_sync  (w_aligned_s)
    );

`ifdef CMAC_LINK_STATS_EN
    logic             w_drop_inc;
    logic [CNT_W-1:0] r_link_drops;
`endif

    // In QUAL/DOWN the state is left on the first opposing sample, so the
    // in-state timer is also the consecutive-sample count.
    always_comb begin
        w_state_nxt = r_state;
        w_retry_inc = 1'b0;
`ifdef CMAC_LINK_STATS_EN
        w_drop_inc  = 1'b0;
`endif
        case (r_state)
            S_RESET: begin
                if (r_timer == c_hold_last) w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_aligned_s) begin
                    w_state_nxt = S_QUAL;
                end else if (r_timer == c_timeout_last) begin
                    w_state_nxt = S_RESET;
                    w_retry_inc = 1'b1;
                end
            end
            S_QUAL: begin
                if (!w_aligned_s)                   w_state_nxt = S_WAIT;
                else if (r_timer == c_debounce_last) w_state_nxt = S_UP;
            end
            S_UP: begin
                if (!w_aligned_s) w_state_nxt = S_DOWN;
            end
            S_DOWN: begin
                if (w_aligned_s) begin
                    w_state_nxt = S_UP;
                end else if (r_timer == c_debounce_last) begin
                    w_state_nxt = S_RESET;
`ifdef CMAC_LINK_STATS_EN
                    w_drop_inc  = 1'b1;
`endif
                end
            end
            default: w_state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge init_clk) begin
        if (init_reset) begin
            r_state       <= S_RESET;
            r_timer       <= '0;
            r_ctl         <= decode_ctl(S_RESET);
            r_retry_count <= '0;
`ifdef CMAC_LINK_STATS_EN
            r_link_drops  <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ctl   <= decode_ctl(w_state_nxt);
            // S_UP has no timed exit, so its timer is parked at zero.
            if (w_state_nxt != r_state || w_state_nxt == S_UP) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_retry_inc && r_retry_count != '1) begin
                r_retry_count <= r_retry_count + 1'b1;
            end
`ifdef CMAC_LINK_STATS_EN
            if (w_drop_inc && r_link_drops != '1) begin
                r_link_drops <= r_link_drops + 1'b1;
            end
`endif
        end
    end

    assign link.cmac_reset      = r_ctl.cmac_reset;
    assign link.ctl_tx_enable   = r_ctl.tx_enable;
    assign link.ctl_tx_send_rfi = r_ctl.send_rfi;
    assign link.link_up         = r_ctl.link_up;
    assign link.retry_count     = r_retry_count;
`ifdef CMAC_LINK_STATS_EN
    assign link.link_drops      = r_link_drops;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cmac_link_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cmac_link_monitor
// Description : Self-checking bench for cmac_link_monitor: cycle model plus
//               directed literal checks and randomized alignment traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cmac_link_monitor;
    localparam int HOLD = 4;
    localparam int DEB  = 8;
    localparam int TO   = 100;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    cmac_link_monitor_if #(.CNT_W(CW)) link ();

    cmac_link_monitor #(
        .RESET_HOLD_CYC    (HOLD),
        .ALIGN_TIMEOUT_CYC (TO),
        .DEBOUNCE_CYC      (DEB),
        .CNT_W             (CW)
    ) dut (
        .init_clk   (clk),
        .init_reset (rst),
        .link       (link.master)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: phase 0=resetting 1=waiting 2=qualifying 3=up 4=glitch-hold,
    // m_n = samples seen in the phase; the synchronizer is a 2-deep delay.
    int m_phase, m_n, m_retry, m_drops;
    bit m_d1, m_d2;

    always @(posedge clk) begin : model
        bit a;
        if (rst) begin
            m_phase = 0; m_n = 0; m_retry = 0; m_drops = 0; m_d1 = 0; m_d2 = 0;
        end else begin
            a = m_d2;
            case (m_phase)
                0: begin m_n++; if (m_n == HOLD) begin m_phase = 1; m_n = 0; end end
                1: if (a) begin m_phase = 2; m_n = 0; end
                   else begin
                       m_n++;
                       if (m_n == TO) begin
                           m_phase = 0; m_n = 0;
                           if (m_retry < CMAX) m_retry++;
                       end
                   end
                2: if (!a) begin m_phase = 1; m_n = 0; end
                   else begin m_n++; if (m_n == DEB) begin m_phase = 3; m_n = 0; end end
                3: if (!a) begin m_phase = 4; m_n = 0; end
                default: if (a) begin m_phase = 3; m_n = 0; end
                   else begin
                       m_n++;
                       if (m_n == DEB) begin
                           m_phase = 0; m_n = 0;
                           if (m_drops < CMAX) m_drops++;
                       end
                   end
            endcase
            m_d2 = m_d1;
            m_d1 = link.stat_rx_aligned;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_cmac_reset", 32'(link.cmac_reset),      32'(m_phase == 0));
            check("m_tx_enable",  32'(link.ctl_tx_enable),   32'(m_phase >= 3));
            check("m_send_rfi",   32'(link.ctl_tx_send_rfi), 32'(m_phase < 3));
            check("m_link_up",    32'(link.link_up),         32'(m_phase >= 3));
            check("m_retry",      32'(link.retry_count),     32'(m_retry));
`ifdef CMAC_LINK_STATS_EN
            check("m_drops",      32'(link.link_drops),      32'(m_drops));
`endif
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        link.stat_rx_aligned = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int hi;
        link.stat_rx_aligned = 1'b0;
        rst = 1'b1;
        tick(2);
        chk_en = 1'b1;
        check("rst_cmac_reset", 32'(link.cmac_reset), 1);
        check("rst_send_rfi",   32'(link.ctl_tx_send_rfi), 1);
        check("rst_tx_enable",  32'(link.ctl_tx_enable), 0);
        check("rst_link_up",    32'(link.link_up), 0);
        check("rst_retry",      32'(link.retry_count), 0);

        // Reset hold length and repeated timeouts with saturation.
        rst = 1'b0;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            if (link.cmac_reset) hi++;
            tick(1);
        end
        check("hold_cycles", 32'(hi), HOLD);
        tick(311 - 10);
        check("retry_before_3rd", 32'(link.retry_count), 2);
        tick(1);
        check("retry_after_3rd", 32'(link.retry_count), 3);
        check("repulse_reset", 32'(link.cmac_reset), 1);
        tick(104);
        check("retry_saturated", 32'(link.retry_count), 3);

        // Bring-up latency: 2 sync + 1 + DEB = 11 cycles.
        do_reset();
        tick(20);
        link.stat_rx_aligned = 1'b1;
        tick(10);
        check("up_minus1", 32'(link.link_up), 0);
        tick(1);
        check("up_link", 32'(link.link_up), 1);
        check("up_tx_en", 32'(link.ctl_tx_enable), 1);
        check("up_rfi", 32'(link.ctl_tx_send_rfi), 0);

        // Short glitch is filtered.
        link.stat_rx_aligned = 1'b0;
        tick(5);
        link.stat_rx_aligned = 1'b1;
        tick(20);
        check("glitch_link_up", 32'(link.link_up), 1);
        check("glitch_cmac_reset", 32'(link.cmac_reset), 0);
`ifdef CMAC_LINK_STATS_EN
        check("glitch_drops", 32'(link.link_drops), 0);
`endif

        // Sustained loss re-resets the core 11 cycles after the drop.
        link.stat_rx_aligned = 1'b0;
        tick(10);
        check("drop_minus1_reset", 32'(link.cmac_reset), 0);
        tick(1);
        check("drop_reset", 32'(link.cmac_reset), 1);
        check("drop_link_up", 32'(link.link_up), 0);
`ifdef CMAC_LINK_STATS_EN
        check("drop_count", 32'(link.link_drops), 1);
`endif

        // Alignment arriving on the timeout cycle wins.
        do_reset();
        tick(101);
        link.stat_rx_aligned = 1'b1;
        tick(3);
        check("tie_retry", 32'(link.retry_count), 0);
        check("tie_cmac_reset", 32'(link.cmac_reset), 0);
        tick(8);
        check("tie_link_up", 32'(link.link_up), 1);

        // init_reset in S_UP with retry_count=2.
        do_reset();
        tick(208);
        check("pre_retry2", 32'(link.retry_count), 2);
        link.stat_rx_aligned = 1'b1;
        tick(20);
        check("pre_up", 32'(link.link_up), 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("ovr_cmac_reset", 32'(link.cmac_reset), 1);
        check("ovr_link_up", 32'(link.link_up), 0);
        check("ovr_retry", 32'(link.retry_count), 0);

        // Randomized alignment traffic, model-checked every cycle.
        for (int it = 0; it < 80; it++) begin
            int len;
            case ($urandom_range(0, 3))
                0:       len = int'($urandom_range(1, 6));
                1:       len = int'($urandom_range(7, 12));
                2:       len = int'($urandom_range(13, 40));
                default: len = int'($urandom_range(90, 130));
            endcase
            link.stat_rx_aligned = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end
            tick(len);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
